// File: rtl/rca_lsq_multiport_pkg.sv
// Shared types and helpers for the RCA load/store queue.
package rca_lsq_multiport_pkg;

    localparam int GRID_NUM_ROWS = 4;
    localparam int MAX_ROWS = 8;

    typedef logic [2:0] fn3_t;

    function automatic logic [3:0] popcount8(input logic [MAX_ROWS-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_ROWS; i++)
            n = n + 4'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/rca_lsq_multiport_tag_fifo.sv
// Row-tag FIFO tracking which grid row owns each outstanding LSU load.
module rca_lsq_multiport_tag_fifo
    import rca_lsq_multiport_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid,
    output logic             full,
    output logic             valid_next,
    output logic [WIDTH-1:0] data_out
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] level;
    logic [CW-1:0] level_n;

    assign level_n = level + CW'(push) - CW'(pop);
    assign valid = (level != '0);
    assign full = (level == CW'(DEPTH));
    assign valid_next = (level_n != '0);
    assign data_out = mem[head];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            level <= '0;
        end else begin
            head <= head + PW'(pop);
            tail <= tail + PW'(push);
            level <= level_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= data_in;
    end

endmodule

// File: rtl/rca_lsq_multiport.sv
// N-wide load/store queue serialising RCA grid requests onto one LSU port
// and steering in-order load returns back to the issuing row.
module rca_lsq_multiport
    import rca_lsq_multiport_pkg::*;
#(
    parameter int NUM_ROWS = GRID_NUM_ROWS,
    parameter int DEPTH = 8,
    parameter int LD_DEPTH = 4,
    parameter int XLEN = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_ROWS-1:0]      row_new_request,
    input  logic [NUM_ROWS-1:0]      row_load,
    input  logic [NUM_ROWS-1:0]      row_store,
    input  logic [3*NUM_ROWS-1:0]    row_fn3,
    input  logic [XLEN*NUM_ROWS-1:0] row_addr,
    input  logic [XLEN*NUM_ROWS-1:0] row_data,
    output logic                     fifo_full,
    output logic [NUM_ROWS-1:0]      row_load_complete,
    output logic [XLEN-1:0]          load_data,
    output logic [XLEN-1:0]          lsu_rs1,
    output logic [XLEN-1:0]          lsu_rs2,
    output logic [2:0]               lsu_fn3,
    output logic                     lsu_load,
    output logic                     lsu_store,
    output logic                     lsu_new_request,
    output logic                     rca_lsu_lock,
    input  logic                     lsu_ready,
    input  logic                     lsu_load_complete,
    input  logic [XLEN-1:0]          lsu_load_data
);
    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic            load;
        logic            store;
        fn3_t            fn3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [RW-1:0]   row;
    } rca_lsq_entry_t;

    rca_lsq_entry_t mem [DEPTH];
    rca_lsq_entry_t head_entry;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] offset [NUM_ROWS];
    logic [CW-1:0] count;
    logic [CW-1:0] count_n;
    logic [CW-1:0] pushes;
    logic [NUM_ROWS-1:0] req;
    logic empty;
    logic issue;
    logic tag_push;
    logic tag_pop;
    logic tag_valid;
    logic tag_full;
    logic tag_valid_next;
    logic [RW-1:0] tag_row;

    // Illegal requests under fifo_full are discarded rather than corrupting the ring.
    assign req = fifo_full ? '0 : (row_new_request & (row_load | row_store));
    assign pushes = CW'(popcount8(MAX_ROWS'(req)));

    always_comb begin
        logic [PW-1:0] k;
        k = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            offset[r] = k;
            k = k + PW'(req[r]);
        end
    end

    assign empty = (count == '0);
    assign head_entry = mem[head];
    assign issue = !empty && lsu_ready && !(head_entry.load && tag_full);
    assign count_n = count + pushes - CW'(issue);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            fifo_full <= 1'b0;
            rca_lsu_lock <= 1'b0;
        end else begin
            head <= head + PW'(issue);
            tail <= tail + PW'(pushes);
            count <= count_n;
            fifo_full <= (CW'(DEPTH) - count_n) < CW'(NUM_ROWS);
            rca_lsu_lock <= (count_n != '0) || tag_valid_next;
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (req[r])
                mem[tail + offset[r]] <= '{
                    load:  row_load[r],
                    store: row_store[r],
                    fn3:   row_fn3[3*r +: 3],
                    addr:  row_addr[XLEN*r +: XLEN],
                    data:  row_data[XLEN*r +: XLEN],
                    row:   RW'(r)
                };
        end
    end

    assign lsu_new_request = issue;
    assign lsu_rs1 = empty ? '0 : head_entry.addr;
    assign lsu_rs2 = empty ? '0 : head_entry.data;
    assign lsu_fn3 = empty ? '0 : head_entry.fn3;
    assign lsu_load = !empty && head_entry.load;
    assign lsu_store = !empty && head_entry.store;

    assign tag_push = issue && head_entry.load;
    assign tag_pop = lsu_load_complete && tag_valid;

    rca_lsq_multiport_tag_fifo #(
        .DEPTH (LD_DEPTH),
        .WIDTH (RW)
    ) tag_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (tag_push),
        .pop        (tag_pop),
        .data_in    (head_entry.row),
        .valid      (tag_valid),
        .full       (tag_full),
        .valid_next (tag_valid_next),
        .data_out   (tag_row)
    );

    always_comb begin
        row_load_complete = '0;
        if (tag_pop)
            row_load_complete[tag_row] = 1'b1;
    end

    assign load_data = tag_pop ? lsu_load_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(fifo_full && (|row_new_request)));
            assert (!(lsu_load_complete && !tag_valid));
        end
    end

endmodule

// File: tb/tb_rca_lsq_multiport.sv
// Scoreboard bench for rca_lsq_multiport: stimulus queues expected LSU
// issues and load returns, a negedge monitor pops and compares them.
module tb_rca_lsq_multiport;
    localparam int N = 4;
    localparam int X = 32;

    logic clk;
    logic rst;
    logic [N-1:0] row_new_request;
    logic [N-1:0] row_load;
    logic [N-1:0] row_store;
    logic [3*N-1:0] row_fn3;
    logic [X*N-1:0] row_addr;
    logic [X*N-1:0] row_data;
    logic fifo_full;
    logic [N-1:0] row_load_complete;
    logic [X-1:0] load_data;
    logic [X-1:0] lsu_rs1;
    logic [X-1:0] lsu_rs2;
    logic [2:0] lsu_fn3;
    logic lsu_load;
    logic lsu_store;
    logic lsu_new_request;
    logic rca_lsu_lock;
    logic lsu_ready;
    logic lsu_load_complete;
    logic [X-1:0] lsu_load_data;

    typedef struct {
        logic ld;
        logic st;
        logic [2:0] fn3;
        logic [31:0] addr;
        logic [31:0] data;
    } iss_t;

    typedef struct {
        logic [N-1:0] rows;
        logic [31:0] data;
    } ret_t;

    iss_t exp_iss [$];
    ret_t exp_ret [$];
    int total = 0;
    int bad = 0;

    rca_lsq_multiport #(
        .NUM_ROWS (N),
        .DEPTH    (8),
        .LD_DEPTH (4),
        .XLEN     (X)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .row_new_request   (row_new_request),
        .row_load          (row_load),
        .row_store         (row_store),
        .row_fn3           (row_fn3),
        .row_addr          (row_addr),
        .row_data          (row_data),
        .fifo_full         (fifo_full),
        .row_load_complete (row_load_complete),
        .load_data         (load_data),
        .lsu_rs1           (lsu_rs1),
        .lsu_rs2           (lsu_rs2),
        .lsu_fn3           (lsu_fn3),
        .lsu_load          (lsu_load),
        .lsu_store         (lsu_store),
        .lsu_new_request   (lsu_new_request),
        .rca_lsu_lock      (rca_lsu_lock),
        .lsu_ready         (lsu_ready),
        .lsu_load_complete (lsu_load_complete),
        .lsu_load_data     (lsu_load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int r, input bit ld, input bit st,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f, input bit track = 1'b1);
        row_new_request[r] = 1'b1;
        row_load[r] = ld;
        row_store[r] = st;
        row_fn3[3*r +: 3] = f;
        row_addr[X*r +: X] = a;
        row_data[X*r +: X] = d;
        if (track)
            exp_iss.push_back('{ld: ld, st: st, fn3: f, addr: a, data: d});
    endtask

    task automatic push_cycle();
        tick();
        row_new_request = '0;
        row_load = '0;
        row_store = '0;
        row_fn3 = '0;
        row_addr = '0;
        row_data = '0;
    endtask

    task automatic ret(input logic [N-1:0] rows, input logic [31:0] d);
        exp_ret.push_back('{rows: rows, data: d});
        lsu_load_complete = 1'b1;
        lsu_load_data = d;
        tick();
        lsu_load_complete = 1'b0;
        lsu_load_data = '0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (lsu_new_request) begin
                if (exp_iss.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_issue: got addr %h want none", lsu_rs1);
                end else begin
                    iss_t e;
                    e = exp_iss.pop_front();
                    check("issue_addr", lsu_rs1, e.addr);
                    check("issue_data", lsu_rs2, e.data);
                    check("issue_fn3", 32'(lsu_fn3), 32'(e.fn3));
                    check("issue_kind", {30'd0, lsu_load, lsu_store}, {30'd0, e.ld, e.st});
                end
            end
            if (|row_load_complete) begin
                if (exp_ret.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_complete: got %b want none", row_load_complete);
                end else begin
                    ret_t e;
                    e = exp_ret.pop_front();
                    check("ret_row", 32'(row_load_complete), 32'(e.rows));
                    check("ret_data", load_data, e.data);
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        row_new_request = '0;
        row_load = '0;
        row_store = '0;
        row_fn3 = '0;
        row_addr = '0;
        row_data = '0;
        lsu_ready = 1'b0;
        lsu_load_complete = 1'b0;
        lsu_load_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_lock", 32'(rca_lsu_lock), 32'd0);
        check("rst_req", 32'(lsu_new_request), 32'd0);
        check("rst_cmpl", 32'(row_load_complete), 32'd0);
        rst = 1'b1;
        tick();

        // single load from row 2
        lsu_ready = 1'b1;
        req(2, 1, 0, 32'h100, 32'h0, 3'd2);
        push_cycle();
        check("lock_after_enq", 32'(rca_lsu_lock), 32'd1);
        check("issue_next_cycle", 32'(lsu_new_request), 32'd1);
        tick();
        ret(4'b0100, 32'hDEADBEEF);
        check("lock_drop", 32'(rca_lsu_lock), 32'd0);

        // four rows at once: stores 0,1 then loads 2,3
        req(0, 0, 1, 32'h200, 32'h11, 3'd2);
        req(1, 0, 1, 32'h204, 32'h22, 3'd2);
        req(2, 1, 0, 32'h300, 32'h0, 3'd2);
        req(3, 1, 0, 32'h304, 32'h0, 3'd2);
        push_cycle();
        repeat (4) tick();
        ret(4'b0100, 32'h0000000A);
        ret(4'b1000, 32'h0000000B);

        // full threshold with the LSU stalled
        lsu_ready = 1'b0;
        for (int r = 0; r < N; r++)
            req(r, 0, 1, 32'h400 + 32'(4 * r), 32'h40 + 32'(r), 3'd0);
        push_cycle();
        check("full_at_4", 32'(fifo_full), 32'd0);
        req(0, 0, 1, 32'h410, 32'h44, 3'd1);
        push_cycle();
        check("full_at_5", 32'(fifo_full), 32'd1);
        check("no_issue_not_ready", 32'(lsu_new_request), 32'd0);
        lsu_ready = 1'b1;
        tick();
        tick();
        lsu_ready = 1'b0;
        check("full_at_3", 32'(fifo_full), 32'd0);
        check("lock_held", 32'(rca_lsu_lock), 32'd1);
        lsu_ready = 1'b1;
        repeat (3) tick();
        check("lock_after_drain", 32'(rca_lsu_lock), 32'd0);

        // outstanding-load limit
        for (int r = 0; r < N; r++)
            req(r, 1, 0, 32'h500 + 32'(4 * r), 32'h0, 3'd2);
        push_cycle();
        req(1, 1, 0, 32'h510, 32'h0, 3'd4);
        push_cycle();
        repeat (3) tick();
        check("load_stall", 32'(lsu_new_request), 32'd0);
        check("lock_stall", 32'(rca_lsu_lock), 32'd1);
        ret(4'b0001, 32'h50);
        check("stall_release", 32'(lsu_new_request), 32'd1);
        tick();
        ret(4'b0010, 32'h51);
        ret(4'b0100, 32'h52);
        ret(4'b1000, 32'h53);
        ret(4'b0010, 32'h54);

        // pointer wrap
        for (int i = 0; i < 12; i++) begin
            req(i % N, 0, 1, 32'h600 + 32'(4 * i), 32'h1000 + 32'(i), 3'(i));
            push_cycle();
        end
        repeat (2) tick();
        check("lock_after_wrap", 32'(rca_lsu_lock), 32'd0);

        // async reset with work in flight
        req(0, 1, 0, 32'h700, 32'h0, 3'd2);
        req(1, 1, 0, 32'h704, 32'h0, 3'd2);
        push_cycle();
        repeat (2) tick();
        lsu_ready = 1'b0;
        for (int r = 0; r < 3; r++)
            req(r, 0, 1, 32'h800 + 32'(r), 32'h0, 3'd0, 1'b0);
        push_cycle();
        check("lock_busy", 32'(rca_lsu_lock), 32'd1);
        #2;
        rst = 1'b0;
        lsu_ready = 1'b1;
        #1;
        check("mid_rst_full", 32'(fifo_full), 32'd0);
        check("mid_rst_lock", 32'(rca_lsu_lock), 32'd0);
        check("mid_rst_req", 32'(lsu_new_request), 32'd0);
        check("mid_rst_cmpl", 32'(row_load_complete), 32'd0);
        lsu_ready = 1'b0;
        tick();
        rst = 1'b1;
        lsu_ready = 1'b1;
        tick();
        check("post_rst_req", 32'(lsu_new_request), 32'd0);
        check("post_rst_lock", 32'(rca_lsu_lock), 32'd0);
        check("iss_drained", 32'(exp_iss.size()), 32'd0);
        check("ret_drained", 32'(exp_ret.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
